hazard_scoreboard: RTL and testbench

- Sequential successor to the per-instruction Tuse/Tnew decoder: a parametrised scoreboard that tracks in-flight destination registers and their Tnew across DEPTH post-decode stages.
- Combines that state with the D-stage instruction's Tuse values to generate the global stall and per-operand forward selects.
- Adds a multi-cycle HI/LO (mult/div) busy counter so the pipeline can stall on mult/div occupancy.
- Sits beside the D stage. Its outputs drive the PC/IF-ID enables, the ID-EX bubble insertion and the D-stage forwarding muxes.

---
 rtl/hazard_scoreboard.sv | 109 ++++++++++
 tb/tb_hazard_scoreboard.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard beside the D stage: tracks in-flight destinations and Tnew,
// and produces the global stall, per-operand forward selects and HI/LO busy.
module hazard_scoreboard #(
  parameter int DEPTH   = 3,
  parameter int TW      = 2,
  parameter int SELW    = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      d_rs,
  input  logic [4:0]      d_rt,
  input  logic [TW-1:0]   d_tuse_rs,
  input  logic [TW-1:0]   d_tuse_rt,
  input  logic            d_uses_md,
  input  logic            d_valid,
  input  logic [4:0]      d_dst,
  input  logic [TW-1:0]   d_tnew,
  input  logic            e_md_start,
  input  logic            e_md_is_div,
  output logic            stall,
  output logic [SELW-1:0] fwd_rs,
  output logic [SELW-1:0] fwd_rt,
  output logic            md_busy
);

  localparam int MAXLAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][4:0]    dst_q, dst_d;
  logic [DEPTH-1:0][TW-1:0] tnew_q, tnew_d;
  logic [CW-1:0]            md_cnt_q, md_cnt_d;

  logic            rs_hit, rt_hit;
  logic [TW-1:0]   rs_tnew, rt_tnew;
  logic [SELW-1:0] rs_sel, rt_sel;
  logic            stall_rs, stall_rt, stall_md;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    rs_tnew = '0;
    rt_tnew = '0;
    rs_sel  = '0;
    rt_sel  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (dst_q[i] == d_rs) && (d_rs != 5'd0)) begin
        rs_hit  = 1'b1;
        rs_tnew = tnew_q[i];
        rs_sel  = SELW'(i + 1);
      end
      if (valid_q[i] && (dst_q[i] == d_rt) && (d_rt != 5'd0)) begin
        rt_hit  = 1'b1;
        rt_tnew = tnew_q[i];
        rt_sel  = SELW'(i + 1);
      end
    end
  end

  assign md_busy  = (md_cnt_q != '0);
  assign stall_rs = rs_hit && (rs_tnew > d_tuse_rs);
  assign stall_rt = rt_hit && (rt_tnew > d_tuse_rt);
  assign stall_md = d_uses_md && (md_busy || e_md_start);
  assign stall    = stall_rs || stall_rt || stall_md;
  assign fwd_rs   = (rs_hit && (rs_tnew == '0)) ? rs_sel : '0;
  assign fwd_rt   = (rt_hit && (rt_tnew == '0)) ? rt_sel : '0;

  // Slot 0 takes a bubble while stalled; older slots keep draining.
  always_comb begin
    valid_d    = '0;
    dst_d      = '0;
    tnew_d     = '0;
    valid_d[0] = d_valid && !stall;
    dst_d[0]   = d_dst;
    tnew_d[0]  = d_tnew;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      dst_d[i]   = dst_q[i-1];
      tnew_d[i]  = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - TW'(1);
    end
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (e_md_start) begin
      md_cnt_d = e_md_is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      dst_q    <= '0;
      tnew_q   <= '0;
      md_cnt_q <= '0;
    end else begin
      valid_q  <= valid_d;
      dst_q    <= dst_d;
      tnew_q   <= tnew_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic
// checked against a cycle-stamped in-flight instruction model.
module tb_hazard_scoreboard;

  localparam int DEPTH   = 3;
  localparam int TW      = 2;
  localparam int SELW    = 2;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [4:0]      d_rs = '0, d_rt = '0, d_dst = '0;
  logic [TW-1:0]   d_tuse_rs = '1, d_tuse_rt = '1, d_tnew = '0;
  logic            d_uses_md = 1'b0, d_valid = 1'b0;
  logic            e_md_start = 1'b0, e_md_is_div = 1'b0;
  logic            stall, md_busy;
  logic [SELW-1:0] fwd_rs, fwd_rt;

  int n_cmp = 0;
  int n_fail = 0;

  hazard_scoreboard #(
    .DEPTH(DEPTH), .TW(TW), .SELW(SELW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_uses_md(d_uses_md),
    .d_valid(d_valid), .d_dst(d_dst), .d_tnew(d_tnew),
    .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // Model: each in-flight instruction remembers the cycle it became visible and
  // its Tnew then; its current Tnew follows from elapsed cycles.
  typedef struct {
    bit valid;
    int dst;
    int enter;
    int tnew0;
  } ent_t;

  ent_t pipe[$];
  int   cyc = 0;
  int   md_end = -1;

  function automatic void lookup(input int r, input int tuse, output bit s, output int f);
    int t;
    s = 1'b0;
    f = 0;
    if (r == 0) return;
    foreach (pipe[k]) begin
      if (pipe[k].valid && pipe[k].dst == r) begin
        t = pipe[k].tnew0 - (cyc - pipe[k].enter);
        if (t < 0) t = 0;
        s = (t > tuse);
        f = (t == 0) ? k + 1 : 0;
        return;
      end
    end
  endfunction

  function automatic void model_eval(output bit st, output int frs, output int frt, output bit bz);
    bit srs, srt;
    bz = (cyc <= md_end);
    lookup(int'(d_rs), int'(d_tuse_rs), srs, frs);
    lookup(int'(d_rt), int'(d_tuse_rt), srt, frt);
    st = srs || srt || (d_uses_md && (bz || e_md_start));
  endfunction

  task automatic tick();
    bit st, bz;
    int a, b;
    ent_t e;
    model_eval(st, a, b, bz);
    @(posedge clk);
    if (reset) begin
      pipe.delete();
      md_end = -1;
    end else begin
      e.valid = d_valid && !st;
      e.dst   = int'(d_dst);
      e.enter = cyc + 1;
      e.tnew0 = int'(d_tnew);
      pipe.push_front(e);
      if (pipe.size() > DEPTH) void'(pipe.pop_back());
      if (e_md_start) md_end = cyc + (e_md_is_div ? DIV_LAT : MUL_LAT);
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    d_rs = '0; d_rt = '0; d_dst = '0;
    d_tuse_rs = '1; d_tuse_rt = '1; d_tnew = '0;
    d_uses_md = 1'b0; d_valid = 1'b0;
    e_md_start = 1'b0; e_md_is_div = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d_rs = 5'($urandom); d_rt = 5'($urandom); d_dst = 5'($urandom);
      d_tuse_rs = TW'($urandom); d_tuse_rt = TW'($urandom); d_tnew = TW'($urandom);
      d_valid = 1'($urandom); d_uses_md = 1'b0;
      e_md_start = 1'($urandom); e_md_is_div = 1'($urandom);
      if (i == 1) begin
        @(negedge clk);
        n_cmp++;
        if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_held: got %0b want 0", md_busy); end
        n_cmp++;
        if (fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin
          n_fail++; $display("FAIL reset_fwd_held: got %0d/%0d want 0/0", fwd_rs, fwd_rt);
        end
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    d_rs = 5'($urandom_range(1, 31)); d_rt = 5'($urandom_range(1, 31));
    d_tuse_rs = '0; d_tuse_rt = '0;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || md_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: stall=%0b busy=%0b want 0/0", stall, md_busy);
    end
    n_cmp++;
    if (fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin
      n_fail++; $display("FAIL reset_release_fwd: got %0d/%0d want 0/0", fwd_rs, fwd_rt);
    end
    tick();
  endtask

  task automatic test_lw_use();
    do_reset();
    d_valid = 1'b1; d_dst = 5'd8; d_tnew = 2'd2;
    tick();
    d_valid = 1'b1; d_dst = 5'd9; d_tnew = 2'd1; d_rs = 5'd8; d_tuse_rs = 2'd1;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b1 || fwd_rs !== 2'd0) begin
      n_fail++; $display("FAIL lw_use_c1: stall=%0b fwd_rs=%0d want 1/0", stall, fwd_rs);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || fwd_rs !== 2'd0) begin
      n_fail++; $display("FAIL lw_use_c2: stall=%0b fwd_rs=%0d want 0/0", stall, fwd_rs);
    end
    tick();
    d_valid = 1'b0; d_dst = 5'd0;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || fwd_rs !== 2'd3) begin
      n_fail++; $display("FAIL lw_use_c3: stall=%0b fwd_rs=%0d want 0/3", stall, fwd_rs);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    d_valid = 1'b1; d_dst = 5'd9; d_tnew = 2'd1;
    tick();
    d_valid = 1'b1; d_dst = 5'd10; d_tnew = 2'd1; d_rt = 5'd9; d_tuse_rt = 2'd1;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || fwd_rt !== 2'd0) begin
      n_fail++; $display("FAIL b2b_c1: stall=%0b fwd_rt=%0d want 0/0", stall, fwd_rt);
    end
    tick();
    d_valid = 1'b0; d_dst = 5'd0;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || fwd_rt !== 2'd2) begin
      n_fail++; $display("FAIL b2b_c2: stall=%0b fwd_rt=%0d want 0/2", stall, fwd_rt);
    end
    tick();
  endtask

  task automatic test_shadowing();
    do_reset();
    d_valid = 1'b1; d_dst = 5'd5; d_tnew = 2'd1;
    tick();
    tick();
    d_valid = 1'b0; d_rs = 5'd5; d_tuse_rs = 2'd0;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b1 || fwd_rs !== 2'd0) begin
      n_fail++; $display("FAIL shadow: stall=%0b fwd_rs=%0d want 1/0", stall, fwd_rs);
    end
    d_rs = 5'd0; d_valid = 1'b1; d_dst = 5'd0; d_tnew = 2'd3;
    tick();
    d_valid = 1'b0; d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd0; d_tuse_rt = 2'd0;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin
      n_fail++; $display("FAIL zero_reg: stall=%0b fwd=%0d/%0d want 0/0/0", stall, fwd_rs, fwd_rt);
    end
    tick();
  endtask

  task automatic test_md_busy();
    do_reset();
    d_uses_md = 1'b1; e_md_start = 1'b1; e_md_is_div = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b1 || md_busy !== 1'b0) begin
      n_fail++; $display("FAIL md_start: stall=%0b busy=%0b want 1/0", stall, md_busy);
    end
    tick();
    e_md_start = 1'b0; e_md_is_div = 1'b0;
    for (int k = 1; k <= DIV_LAT; k++) begin
      @(negedge clk);
      n_cmp++;
      if (stall !== 1'b1 || md_busy !== 1'b1) begin
        n_fail++; $display("FAIL md_div_busy[%0d]: stall=%0b busy=%0b want 1/1", k, stall, md_busy);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || md_busy !== 1'b0) begin
      n_fail++; $display("FAIL md_div_done: stall=%0b busy=%0b want 0/0", stall, md_busy);
    end
    d_uses_md = 1'b0; e_md_start = 1'b1; e_md_is_div = 1'b1;
    tick();
    e_md_start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (stall !== 1'b0 || md_busy !== 1'b1) begin
        n_fail++; $display("FAIL md_nouse[%0d]: stall=%0b busy=%0b want 0/1", k, stall, md_busy);
      end
      tick();
    end
    e_md_start = 1'b1; e_md_is_div = 1'b0;
    tick();
    e_md_start = 1'b0;
    for (int k = 1; k <= MUL_LAT; k++) begin
      @(negedge clk);
      n_cmp++;
      if (md_busy !== 1'b1) begin
        n_fail++; $display("FAIL md_restart[%0d]: busy=%0b want 1", k, md_busy);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++;
    if (md_busy !== 1'b0) begin
      n_fail++; $display("FAIL md_restart_done: busy=%0b want 0", md_busy);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    e_md_start = 1'b1; e_md_is_div = 1'b1;
    tick();
    e_md_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) begin d_valid = 1'b1; d_dst = 5'd8; d_tnew = 2'd3; end
      tick();
    end
    d_valid = 1'b0; d_rs = 5'd8; d_tuse_rs = 2'd0; d_uses_md = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b1 || md_busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: stall=%0b busy=%0b want 1/1", stall, md_busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || md_busy !== 1'b0 || fwd_rs !== 2'd0) begin
      n_fail++; $display("FAIL mid_post: stall=%0b busy=%0b fwd_rs=%0d want 0/0/0", stall, md_busy, fwd_rs);
    end
    tick();
  endtask

  task automatic test_random();
    bit est, ebz;
    int efr, eft;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 59) == 0);
      d_rs        = 5'($urandom_range(0, 3));
      d_rt        = 5'($urandom_range(0, 3));
      d_dst       = 5'($urandom_range(0, 3));
      d_tuse_rs   = TW'($urandom);
      d_tuse_rt   = TW'($urandom);
      d_tnew      = TW'($urandom);
      d_valid     = ($urandom_range(0, 3) != 0);
      d_uses_md   = ($urandom_range(0, 3) == 0);
      e_md_start  = ($urandom_range(0, 11) == 0);
      e_md_is_div = 1'($urandom);
      @(negedge clk);
      model_eval(est, efr, eft, ebz);
      n_cmp++;
      if (stall !== est || int'(fwd_rs) != efr || int'(fwd_rt) != eft || md_busy !== ebz) begin
        n_fail++;
        $display("FAIL random[%0d]: got stall=%0b rs=%0d rt=%0d busy=%0b want %0b/%0d/%0d/%0b",
                 n, stall, fwd_rs, fwd_rt, md_busy, est, efr, eft, ebz);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_lw_use();
    test_back_to_back();
    test_shadowing();
    test_md_busy();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
